register_file: RTL

- Operand-source and write-back end of the datapath ALU interface: drives the two ALU operand buses BusA/BusB and captures the ALU result BusW.
- Used in the single-cycle LEGv8 datapath: 32 x 64-bit general registers, two combinational read ports, one clocked write port.
- Register X31 is XZR: it always reads zero and ignores writes.

---
 rtl/register_file.sv | 58 +++++
 1 files changed

// File: rtl/register_file.sv
// register_file: 32 x 64-bit LEGv8 general register file.
// Two combinational read ports (BusA/BusB) and one clocked write port (BusW).
// Index ZERO_REG (X31 / XZR) always reads zero and drops writes.
// Asynchronous active-high Reset clears every location.
// Optional feature: define REGFILE_BYPASS_EN to forward BusW onto a read port
// in the same cycle as a matching write (write-through forwarding).
module register_file #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic                  RegWr,
  input  logic [DATA_WIDTH-1:0] BusW,
  output logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] BusB
);

  localparam int Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroIdx = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic                  wr_en;

  // A write is effective only when enabled and not aimed at XZR.
  assign wr_en = RegWr && (RW != ZeroIdx);

  // Storage: async clear on Reset, otherwise capture BusW into reg[RW] on the rising edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[RW] <= BusW;
    end
  end

  // Read ports: combinational lookup with XZR forced to zero (plus optional forwarding).
  always_comb begin
    BusA = (RA == ZeroIdx) ? '0 : regs_q[RA];
    BusB = (RB == ZeroIdx) ? '0 : regs_q[RB];
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes XZR, so the zero register is never forwarded.
    if (!Reset && wr_en && (RW == RA)) begin
      BusA = BusW;
    end
    if (!Reset && wr_en && (RW == RB)) begin
      BusB = BusW;
    end
`endif
  end

endmodule
